spi_bus_bridge: RTL
===================

# spi_bus_bridge

SPI-slave-to-peripheral-bus bridge: an external SPI host (mode 0, MSB first) issues single-byte read/write cycles on the on-chip peripheral bus (AD/data/rw/cs). It is the initiator end of that bus, driving the GPIO block and any other peripheral in its place. An `irq` line is reported back to the host in a status byte. All logic runs in the `clk` domain; SPI inputs are oversampled.

## Interface
- `SYNC_STAGES`, default 2: synchronizer depth on `spi_sck`, `spi_mosi`, `spi_ss_n`, `irq` (minimum 2).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `spi_sck`  in  1  SPI clock from host, asynchronous; f_sck ≤ f_clk/16.
- `spi_ss_n`  in  1  SPI select, active low, asynchronous.
- `spi_mosi`  in  1  host → bridge data.
- `spi_miso`  out  1  bridge → host data; driven at all times, 0 while deselected.
- `AD`  out  4  peripheral register address.
- `DO`  out  8  write data to peripheral `DI`.
- `DI`  in  8  read data from peripheral `DO`, registered by the peripheral.
- `rw`  out  1  1 = read, 0 = write.
- `cs`  out  1  peripheral select, one-cycle strobe.
- `irq`  in  1  peripheral interrupt level, asynchronous.

## Operation
- Frame: `spi_ss_n` low, 16 bits. Byte 0 = command: bit7 = rw, bits6:4 reserved (ignored), bits3:0 = AD. Byte 1 = write data (write) or read data on MISO (read).
- MISO during byte 0 = status {irq_sync, 7'b0}, sampled at the ss_n falling-edge detect.
- MOSI sampled on detected SCK rising edge; MISO updated on detected SCK falling edge; first status bit presented on ss_n falling-edge detect.
- States: IDLE → CMD (8 bits) → read: RD_CS → RD_WAIT → RD_CAP → DATA; write: DATA (8 bits) → WR_CS → DONE. DONE/DATA end → DONE until ss_n high → IDLE.
- Read: bus cycle issued right after 8th bit; captured DI is loaded into the MISO shifter, MSB presented on 8th falling edge.
- Write: bus cycle issued only after the 16th rising edge.
- Bits beyond 16 in one frame: ignored, MISO 0, no further bus cycles.
- ss_n deasserted before bit 8 (read) or bit 16 (write): abort to IDLE, no bus cycle; a read already issued is not undone.
- ss_n low-edge while in any non-IDLE state (glitchless re-select not seen high): treated as continuation; the host must hold ss_n high ≥ 4 clk between frames.
- Reset (including mid-frame): state IDLE, `cs`=0, `rw`=1, `AD`=0, `DO`=0, `spi_miso`=0, shifters and bit counter cleared; the current frame is discarded until ss_n is seen high.

## Timing
- Input synchronization: SYNC_STAGES clk + 1 clk edge detect.
- `cs` high exactly one clk per bus cycle; `AD`, `rw`, `DO` valid in that cycle and held unchanged until the next bus cycle.
- Read: `cs` at cycle T, `DI` sampled at the end of T+1 (peripheral registers data on the T edge); MISO shifter loaded at T+2.
- Read path, from 8th SCK rising pin edge to valid MISO: ≤ SYNC_STAGES + 5 clk, < half SCK period at f_sck ≤ f_clk/16.
- Write: `cs` asserted 1 clk after the 16th rising edge is detected.
- ss_n setup to first SCK rising edge ≥ 4 clk.

## Structure
- Shared package `spi_bridge_pkg`: state encoding, command field positions (RW_BIT=7, AD_MSB=3), status byte layout, frame length 16.
- Sub-module `spi_sync_edge`: SYNC_STAGES flop chain plus rise/fall detect, instantiated for `spi_sck` and `spi_ss_n`; plain synchronizers for `spi_mosi` and `irq`.
- Top: FSM, 4-bit bit counter, 8-bit RX shifter, 8-bit TX shifter, bus output registers.

## Test plan
- Write frame 0x03, 0x5A → exactly one `cs` pulse with `rw`=0, `AD`=3, `DO`=0x5A; MISO byte 0 = 0x00 with `irq`=0.
- Read frame 0x81, dummy 0x00, with peripheral model registering `DI`=0xC3 → one `cs` pulse with `rw`=1, `AD`=1; MISO byte 1 = 0xC3.
- `irq`=1 before the frame → MISO byte 0 = 0x80; command 0xF5 (reserved bits set) → read of AD=5.
- Write frame aborted after 12 bits → no `cs`; the next full write 0x02, 0xA5 → one pulse, `AD`=2, `DO`=0xA5.
- 24-bit frame 0x04, 0x11, 0x22 → one write (`AD`=4, `DO`=0x11), last byte on MISO = 0x00; back-to-back frames with 4-clk gap → both cycles issued.
- `rst` asserted at bit 10 of a write → outputs return to reset values, no `cs` for that frame, the next frame works normally.

Source files
------------

// File: rtl/spi_bridge_pkg.sv
// Shared definitions for the SPI-to-peripheral-bus bridge: FSM encoding,
// command byte field positions, status byte layout and frame length.
package spi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_RD_CS,
    ST_RD_WAIT,
    ST_RD_CAP,
    ST_DATA,
    ST_WR_CS,
    ST_DONE
  } state_t;

  localparam int RW_BIT         = 7;
  localparam int AD_MSB         = 3;
  localparam int STATUS_IRQ_BIT = 7;
  localparam int FRAME_BITS     = 16;

  localparam logic [3:0] LAST_CMD_BIT  = 4'd7;
  localparam logic [3:0] LAST_DATA_BIT = 4'(FRAME_BITS - 1);

  function automatic logic [7:0] status_byte(input logic irq_level);
    logic [7:0] s;
    s = '0;
    s[STATUS_IRQ_BIT] = irq_level;
    return s;
  endfunction

endpackage

// File: rtl/spi_bus_bridge_sync_edge.sv
// Multi-stage synchronizer for an asynchronous input, with one extra flop
// used to detect rising and falling edges of the synchronized level.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], din};
    prev_d = sync_q[STAGES-1];
  end

  // Reset to 0 so a line already low at reset never produces a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~prev_q;
  assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave that turns 16-bit frames into single-byte read/write
// cycles on the peripheral bus, reporting irq in the first MISO byte.
module spi_bus_bridge
  import spi_bridge_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_ss_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [3:0] AD,
  output logic [7:0] DO,
  input  logic [7:0] DI,
  output logic       rw,
  output logic       cs,
  input  logic       irq
);

  logic sck_level, sck_rise, sck_fall;
  logic ss_high, ss_rise, ss_fall;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_sck),
    .level (sck_level),
    .rise  (sck_rise),
    .fall  (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (spi_ss_n),
    .level (ss_high),
    .rise  (ss_rise),
    .fall  (ss_fall)
  );

  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] irq_sync_q, irq_sync_d;
  logic                   mosi_s, irq_s;

  state_t     state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_q, rx_d, rx_next;
  logic [7:0] tx_q, tx_d, status;
  logic       miso_q, miso_d;
  logic       cs_q, cs_d;
  logic       rw_q, rw_d;
  logic [3:0] ad_q, ad_d;
  logic [7:0] do_q, do_d;
  logic       cmd_rw_q, cmd_rw_d;
  logic [3:0] cmd_ad_q, cmd_ad_d;

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign irq_s  = irq_sync_q[SYNC_STAGES-1];
  assign status = status_byte(irq_s);

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    irq_sync_d  = {irq_sync_q[SYNC_STAGES-2:0], irq};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_d        = rx_q;
    tx_d        = tx_q;
    miso_d      = miso_q;
    cs_d        = 1'b0;
    rw_d        = rw_q;
    ad_d        = ad_q;
    do_d        = do_q;
    cmd_rw_d    = cmd_rw_q;
    cmd_ad_d    = cmd_ad_q;
    rx_next     = {rx_q[6:0], mosi_s};

    // Deselect ends or aborts any frame; an issued read still completes on the bus
    // because its cs strobe is already registered.
    if (state_q != ST_IDLE && ss_high) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      miso_d    = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          miso_d = 1'b0;
          if (ss_fall) begin
            state_d   = ST_CMD;
            bit_cnt_d = '0;
            rx_d      = '0;
            miso_d    = status[7];
            tx_d      = {status[6:0], 1'b0};
          end
        end
        ST_CMD: begin
          if (sck_rise) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_CMD_BIT) begin
              cmd_rw_d = rx_next[RW_BIT];
              cmd_ad_d = rx_next[AD_MSB:0];
              tx_d     = '0;
              if (rx_next[RW_BIT]) begin
                state_d = ST_RD_CS;
                cs_d    = 1'b1;
                rw_d    = 1'b1;
                ad_d    = rx_next[AD_MSB:0];
              end else begin
                state_d = ST_DATA;
              end
            end
          end else if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        ST_RD_CS:   state_d = ST_RD_WAIT;
        ST_RD_WAIT: begin
          tx_d    = DI;
          state_d = ST_RD_CAP;
        end
        ST_RD_CAP:  state_d = ST_DATA;
        ST_DATA: begin
          if (sck_rise) begin
            rx_d      = rx_next;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == LAST_DATA_BIT) begin
              if (!cmd_rw_q) begin
                state_d = ST_WR_CS;
                cs_d    = 1'b1;
                rw_d    = 1'b0;
                ad_d    = cmd_ad_q;
                do_d    = rx_next;
              end else begin
                state_d = ST_DONE;
              end
            end
          end else if (sck_fall) begin
            miso_d = tx_q[7];
            tx_d   = {tx_q[6:0], 1'b0};
          end
        end
        ST_WR_CS: state_d = ST_DONE;
        ST_DONE: begin
          if (sck_fall) begin
            miso_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mosi_sync_q <= '0;
      irq_sync_q  <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_q        <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      cs_q        <= 1'b0;
      rw_q        <= 1'b1;
      ad_q        <= '0;
      do_q        <= '0;
      cmd_rw_q    <= 1'b0;
      cmd_ad_q    <= '0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
      irq_sync_q  <= irq_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_q        <= rx_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      cs_q        <= cs_d;
      rw_q        <= rw_d;
      ad_q        <= ad_d;
      do_q        <= do_d;
      cmd_rw_q    <= cmd_rw_d;
      cmd_ad_q    <= cmd_ad_d;
    end
  end

  assign spi_miso = miso_q;
  assign cs       = cs_q;
  assign rw       = rw_q;
  assign AD       = ad_q;
  assign DO       = do_q;

  // Edge detects on these lines are not needed by the FSM.
  logic unused_edges;
  assign unused_edges = sck_level ^ ss_rise;

endmodule
